// File: rtl/uart_rxer.sv
// 8N1 UART receiver: two-flop synchroniser, start-bit centring, LSB-first byte
// assembly, one-cycle data/framing-error strobes.
module uart_rxer #(
  parameter int CLKS_PER_BIT = 5000
) (
  input  logic       clk,
  input  logic       res,
  input  logic       RX,
  output logic [7:0] data_out,
  output logic       en_data_out,
  output logic       frame_err,
  output logic       busy
);

  localparam int HALF_BIT = CLKS_PER_BIT / 2;
  localparam int CW       = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF = CW'(HALF_BIT - 1);

  typedef enum logic [2:0] {WAIT_IDLE, IDLE, START, DATA, STOP} state_t;

  state_t        state;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    shift_reg;
  logic          rx_m, rx_s;
  // rx_s holds its reset value for two edges; WAIT_IDLE ignores it until a real
  // line sample has propagated, so a line held low through reset is not idle.
  logic [1:0]    sync_vld;

  always_ff @(posedge clk) begin
    if (!res) begin
      state       <= WAIT_IDLE;
      cnt         <= '0;
      bit_idx     <= '0;
      shift_reg   <= '0;
      rx_m        <= 1'b1;
      rx_s        <= 1'b1;
      sync_vld    <= '0;
      data_out    <= '0;
      en_data_out <= 1'b0;
      frame_err   <= 1'b0;
      busy        <= 1'b0;
    end else begin
      rx_m        <= RX;
      rx_s        <= rx_m;
      sync_vld    <= {sync_vld[0], 1'b1};
      en_data_out <= 1'b0;
      frame_err   <= 1'b0;
      case (state)
        WAIT_IDLE: if (rx_s && sync_vld[1]) state <= IDLE;
        IDLE: if (!rx_s) begin
          state <= START;
          cnt   <= '0;
          busy  <= 1'b1;
        end
        START: if (cnt == CNT_HALF) begin
          if (rx_s) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            state   <= DATA;
            cnt     <= '0;
            bit_idx <= '0;
          end
        end else cnt <= cnt + 1'b1;
        DATA: if (cnt == CNT_LAST) begin
          cnt       <= '0;
          shift_reg <= {rx_s, shift_reg[7:1]};
          if (bit_idx == 3'd7) state <= STOP;
          else bit_idx <= bit_idx + 1'b1;
        end else cnt <= cnt + 1'b1;
        STOP: if (cnt == CNT_LAST) begin
          cnt  <= '0;
          busy <= 1'b0;
          if (rx_s) begin
            data_out    <= shift_reg;
            en_data_out <= 1'b1;
            state       <= IDLE;
          end else begin
            frame_err <= 1'b1;
            state     <= WAIT_IDLE;
          end
        end else cnt <= cnt + 1'b1;
        default: begin
          state <= WAIT_IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
